// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared constants and state encoding for the sequential
// restoring divider. The width constants are also meant for the multiplier
// side, so that A*B products can be round-tripped through the divider.
package seq_divider_pkg;

  localparam int DIV_N_BITS = 16;  // dividend / quotient width
  localparam int DIV_D_BITS = 8;   // divisor / remainder width
  localparam int DIV_ITERS  = DIV_N_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration.
//   pr_i      : current partial remainder (D_BITS+1 wide)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   pr_o      : partial remainder after shift and conditional subtract
//   qbit_o    : quotient bit produced by this iteration
module div_step #(
  parameter int D_BITS = 8
) (
  input  logic [D_BITS:0]   pr_i,
  input  logic              bit_i,
  input  logic [D_BITS-1:0] divisor_i,
  output logic [D_BITS:0]   pr_o,
  output logic              qbit_o
);

  // Keep the shifted value one bit wider than pr so the compare sees the
  // whole shifted quantity, even though pr < divisor keeps the top bit 0.
  logic [D_BITS+1:0] shifted;

  assign shifted = {pr_i, bit_i};
  assign qbit_o  = shifted >= (D_BITS+2)'(divisor_i);
  assign pr_o    = qbit_o ? (D_BITS+1)'(shifted - (D_BITS+2)'(divisor_i))
                          : shifted[D_BITS:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, N_BITS / D_BITS.
// One iteration per clock; a division takes 18 cycles start to start.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : request, sampled only in IDLE
//   dividend, divisor    : operands, captured on the accepting edge
//   busy                 : high from accept until return to IDLE
//   done                 : one-cycle result-valid pulse
//   quotient, remainder  : results, held until the next completed division
//   dz                   : divide-by-zero flag, updated with the results
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N_BITS = DIV_N_BITS,
  parameter int D_BITS = DIV_D_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] dividend,
  input  logic [D_BITS-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] quotient,
  output logic [D_BITS-1:0] remainder,
  output logic              dz
);

  localparam int CW = $clog2(N_BITS) + 1;

  div_state_e        state_q;
  logic [N_BITS-1:0] dvd_q;     // dividend shifts out MSB-first, quotient bits shift in
  logic [D_BITS-1:0] dvs_q;
  logic [D_BITS:0]   pr_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, dz_q;
  logic [N_BITS-1:0] quot_q;
  logic [D_BITS-1:0] rem_q;

  logic [D_BITS:0]   pr_d;
  logic              qbit_d;

  div_step #(.D_BITS(D_BITS)) u_step (
    .pr_i      (pr_q),
    .bit_i     (dvd_q[N_BITS-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            pr_q   <= '0;
            cnt_q  <= '0;
            if (divisor == '0) begin
              // Divide by zero skips the iterations entirely.
              quot_q  <= '1;
              rem_q   <= dividend[D_BITS-1:0];
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          pr_q  <= pr_d;
          dvd_q <= {dvd_q[N_BITS-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N_BITS - 1)) begin
            quot_q  <= {dvd_q[N_BITS-2:0], qbit_d};
            rem_q   <= pr_d[D_BITS-1:0];
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, dz;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int checks = 0;
  int errors = 0;

  // Results the outputs must hold between operations (from the model).
  logic [15:0] prev_q = '0;
  logic [7:0]  prev_r = '0;
  logic        prev_dz = 1'b0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full division. repulse >= 0 pulses start with other operands at
  // that RUN cycle, which must be ignored.
  task automatic run_div(input logic [15:0] n, input logic [7:0] d, input int repulse);
    int          lat;
    bit          stable;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    edz = (d == 0);
    eq  = edz ? 16'hFFFF : n / {8'd0, d};
    er  = edz ? n[7:0] : 8'(n % {8'd0, d});
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    chk("busy_on_accept", {31'd0, busy}, 32'd1);
    lat = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (quotient !== prev_q || remainder !== prev_r || dz !== prev_dz) stable = 1'b0;
      if (lat == repulse) begin
        start = 1'b1; dividend = ~n; divisor = (d ^ 8'h5A) | 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, edz ? 32'd0 : 32'd16);
    chk("held_while_running", {31'd0, stable}, 32'd1);
    chk("quotient", {16'd0, quotient}, {16'd0, eq});
    chk("remainder", {24'd0, remainder}, {24'd0, er});
    chk("dz", {31'd0, dz}, {31'd0, edz});
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_cleared", {31'd0, busy}, 32'd0);
    chk("quotient_held", {16'd0, quotient}, {16'd0, eq});
    prev_q = eq; prev_r = er; prev_dz = edz;
  endtask

  initial begin
    int cnt;
    int pulses;
    bit seen_low;
    logic [15:0] rn;
    logic [7:0]  rd;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Directed cases
    run_div(16'd65025, 8'd255, -1);
    run_div(16'd65535, 8'd7, -1);
    run_div(16'd100, 8'd200, -1);
    run_div(16'd1234, 8'd0, -1);
    run_div(16'd50000, 8'd123, 5);

    // start held high: second accept 18 edges after the first
    @(negedge clk);
    start = 1'b1; dividend = 16'd300; divisor = 8'd7;
    @(posedge clk); #1;
    chk("held_start_accept", {31'd0, busy}, 32'd1);
    cnt = 0; seen_low = 1'b0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) seen_low = 1'b1;
      else if (seen_low) break;
    end
    start = 1'b0;
    chk("reaccept_interval", cnt, 32'd18);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("held_start_q", {16'd0, quotient}, 32'd42);
    chk("held_start_r", {24'd0, remainder}, 32'd6);
    @(posedge clk); #1;
    prev_q = 16'd42; prev_r = 8'd6; prev_dz = 1'b0;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; dividend = 16'd5000; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    run_div(16'd1000, 8'd10, -1);

    // Random sweep with forced corners mixed in
    for (int i = 0; i < 1500; i++) begin
      rn = 16'($urandom);
      rd = 8'($urandom);
      case (i % 10)
        0: rd = 8'd1;
        1: rn = 16'd0;
        2: rd = 8'd0;
        3: rd = 8'd255;
        default: ;
      endcase
      run_div(rn, rd, (i % 7 == 0) ? int'($urandom_range(0, 15)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
